// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and helpers for the scoreboarded register file.
//   DEF_DATA_W / DEF_ADDR_W : default register width and index width
//   R0_IDX                  : index of the hardwired-zero register
//   PARITY_W                : widest data vector f_parity accepts (zero-extended)
//   f_parity                : even-parity bit of a data word
package regfile_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned R0_IDX     = 0;
  localparam int unsigned PARITY_W   = 64;

  // Zero-extension does not change parity, so narrower words can be passed in
  function automatic logic f_parity(input logic [PARITY_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits and RAW stall detection.
//   clk, clrn              : clock, async active-low reset
//   rna, rnb, use_a, use_b : ID source indices and their consume qualifiers
//   we, wn                 : WB writeback (clears busy, forwards data)
//   issue_en, issue_rn     : ID issue (sets busy on destination)
//   flush                  : clear every busy bit
//   busy                   : scoreboard vector
//   stall                  : combinational RAW hazard request to ID
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     clrn,
  input  logic [ADDR_W-1:0]        rna,
  input  logic [ADDR_W-1:0]        rnb,
  input  logic                     use_a,
  input  logic                     use_b,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wn,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_rn,
  input  logic                     flush,
  output logic [(1<<ADDR_W)-1:0]   busy,
  output logic                     stall
);

  localparam int unsigned NREG = 1 << ADDR_W;

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic            haz_a;
  logic            haz_b;

  // Next busy state: issue beats flush beats writeback
  always_comb begin
    busy_d = busy_q;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (issue_en && (issue_rn == ADDR_W'(i))) begin
        busy_d[i] = 1'b1;
      end else if (flush) begin
        busy_d[i] = 1'b0;
      end else if (we && (wn == ADDR_W'(i))) begin
        busy_d[i] = 1'b0;
      end
    end
    if (ZERO_REG != 0) begin
      busy_d[R0_IDX] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // A source being written this cycle is forwarded, so it never stalls
  always_comb begin
    haz_a = busy_q[rna] && !(we && (wn == rna));
    haz_b = busy_q[rnb] && !(we && (wn == rnb));
    stall = (use_a && haz_a) || (use_b && haz_b);
  end

  assign busy = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: 2R/1W register file with write-through bypass and busy scoreboard.
//   clk, clrn          : clock, async active-low reset
//   rna/rnb -> qa/qb   : combinational read ports (r0 = 0 when ZERO_REG)
//   use_a, use_b       : ID consume qualifiers for stall
//   we, wn, d          : WB write port
//   issue_en, issue_rn : ID issue, marks destination busy
//   flush              : clear all busy bits
//   stall, busy        : hazard request and scoreboard vector
//   perr_a, perr_b     : read parity error, only with REGFILE_SB_PARITY_EN
// Optional feature macro: REGFILE_SB_PARITY_EN (per-register even parity).
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     clrn,
  input  logic [ADDR_W-1:0]        rna,
  input  logic [ADDR_W-1:0]        rnb,
  output logic [DATA_W-1:0]        qa,
  output logic [DATA_W-1:0]        qb,
  input  logic                     use_a,
  input  logic                     use_b,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wn,
  input  logic [DATA_W-1:0]        d,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_rn,
  input  logic                     flush,
  output logic                     stall,
  output logic [(1<<ADDR_W)-1:0]   busy
`ifdef REGFILE_SB_PARITY_EN
  ,
  output logic                     perr_a,
  output logic                     perr_b
`endif
);

  localparam int unsigned NREG = 1 << ADDR_W;

  logic [NREG-1:0][DATA_W-1:0] reg_q;
  logic                        wr_en;
  logic                        zero_a;
  logic                        zero_b;
  logic                        byp_a;
  logic                        byp_b;

  // Writes to r0 are dropped when it is hardwired
  always_comb begin
    wr_en  = we && !((ZERO_REG != 0) && (wn == ADDR_W'(R0_IDX)));
    zero_a = (ZERO_REG != 0) && (rna == ADDR_W'(R0_IDX));
    zero_b = (ZERO_REG != 0) && (rnb == ADDR_W'(R0_IDX));
    // Bypass qualified by clrn so reads stay 0 throughout reset
    byp_a  = clrn && we && (wn == rna);
    byp_b  = clrn && we && (wn == rnb);
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      reg_q <= '0;
    end else if (wr_en) begin
      reg_q[wn] <= d;
    end
  end

  // Read mux: zero register, then write-through bypass, then storage
  always_comb begin
    qa = reg_q[rna];
    qb = reg_q[rnb];
    if (byp_a) qa = d;
    if (byp_b) qb = d;
    if (zero_a) qa = '0;
    if (zero_b) qb = '0;
  end

`ifdef REGFILE_SB_PARITY_EN
  logic [NREG-1:0] par_q;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      par_q <= '0;
    end else if (wr_en) begin
      par_q[wn] <= f_parity(PARITY_W'(d));
    end
  end

  // Parity is checked against storage only; bypassed and r0 reads report clean
  always_comb begin
    perr_a = par_q[rna] ^ f_parity(PARITY_W'(reg_q[rna]));
    perr_b = par_q[rnb] ^ f_parity(PARITY_W'(reg_q[rnb]));
    if (byp_a || zero_a) perr_a = 1'b0;
    if (byp_b || zero_b) perr_b = 1'b0;
  end
`endif

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .clrn     (clrn),
    .rna      (rna),
    .rnb      (rnb),
    .use_a    (use_a),
    .use_b    (use_b),
    .we       (we),
    .wn       (wn),
    .issue_en (issue_en),
    .issue_rn (issue_rn),
    .flush    (flush),
    .busy     (busy),
    .stall    (stall)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed stimulus with an expectation queue drained by a monitor.
module tb_regfile_sb;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  typedef enum int {K_QA, K_QB, K_BUSY, K_STALL, K_PERR_A} kind_e;
  typedef struct {
    string       name;
    kind_e       kind;
    logic [31:0] exp;
  } exp_t;

  logic          clk = 1'b0;
  logic          clrn;
  logic [AW-1:0] rna, rnb, wn, issue_rn;
  logic [DW-1:0] qa, qb, d;
  logic          use_a, use_b, we, issue_en, flush, stall;
  logic [31:0]   busy;
`ifdef REGFILE_SB_PARITY_EN
  logic          perr_a, perr_b;
`endif

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (
    .clk      (clk),
    .clrn     (clrn),
    .rna      (rna),
    .rnb      (rnb),
    .qa       (qa),
    .qb       (qb),
    .use_a    (use_a),
    .use_b    (use_b),
    .we       (we),
    .wn       (wn),
    .d        (d),
    .issue_en (issue_en),
    .issue_rn (issue_rn),
    .flush    (flush),
    .stall    (stall),
    .busy     (busy)
`ifdef REGFILE_SB_PARITY_EN
    ,
    .perr_a   (perr_a),
    .perr_b   (perr_b)
`endif
  );

  always #5 clk = ~clk;

  // Monitor: outputs are settled mid-cycle, so drain expectations on negedge
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e.kind)
        K_QA:     act = qa;
        K_QB:     act = qb;
        K_BUSY:   act = busy;
        K_STALL:  act = {31'd0, stall};
`ifdef REGFILE_SB_PARITY_EN
        K_PERR_A: act = {31'd0, perr_a};
`endif
        default:  act = 32'hxxxx_xxxx;
      endcase
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
    end
  end

  task automatic expect_v(input string name, input kind_e kind, input logic [31:0] v);
    exp_t e;
    e.name = name;
    e.kind = kind;
    e.exp  = v;
    exp_q.push_back(e);
  endtask

  // Advance to just after the next rising edge and return all inputs to idle
  task automatic step();
    @(posedge clk);
    #1;
    use_a = 0; use_b = 0; we = 0; wn = '0; d = '0;
    issue_en = 0; issue_rn = '0; flush = 0;
  endtask

  initial begin
    int guard;
    clrn = 0; rna = '0; rnb = '0; use_a = 0; use_b = 0;
    we = 0; wn = '0; d = '0; issue_en = 0; issue_rn = '0; flush = 0;

    // Outputs held at zero in reset
    rna = 5'd3; rnb = 5'd4;
    expect_v("rst_qa", K_QA, 32'h0);
    expect_v("rst_qb", K_QB, 32'h0);
    expect_v("rst_busy", K_BUSY, 32'h0);
    expect_v("rst_stall", K_STALL, 32'h0);
    step();
    clrn = 1;

    // Reset asserted while a write to r3 is pending
    step();
    we = 1; wn = 5'd3; d = 32'hDEAD_BEEF; rna = 5'd3;
    #2 clrn = 0;
    expect_v("rst_mid_qa", K_QA, 32'h0);
    step();
    clrn = 1; rna = 5'd3;
    expect_v("rst_r3_qa", K_QA, 32'h0);
    expect_v("rst_r3_busy", K_BUSY, 32'h0);
    expect_v("rst_r3_stall", K_STALL, 32'h0);

    // Write-through bypass then storage read, both ports on r5
    step();
    we = 1; wn = 5'd5; d = 32'h1234_5678; rna = 5'd5; rnb = 5'd5;
    expect_v("byp_qa", K_QA, 32'h1234_5678);
    expect_v("byp_qb", K_QB, 32'h1234_5678);
    step();
    rna = 5'd5; rnb = 5'd5;
    expect_v("stored_qa", K_QA, 32'h1234_5678);
    expect_v("stored_qb", K_QB, 32'h1234_5678);

    // r0 ignores writes and issues
    step();
    we = 1; wn = 5'd0; d = 32'hFFFF_FFFF; issue_en = 1; issue_rn = 5'd0; rna = 5'd0;
    expect_v("r0_byp_qa", K_QA, 32'h0);
    step();
    rna = 5'd0;
    expect_v("r0_qa", K_QA, 32'h0);
    expect_v("r0_busy", K_BUSY, 32'h0);

    // Load-use hazard on r7
    step();
    issue_en = 1; issue_rn = 5'd7;
    step();
    rna = 5'd7; use_a = 1;
    expect_v("r7_busy", K_BUSY, 32'h0000_0080);
    expect_v("r7_stall", K_STALL, 32'h1);
    step();
    rna = 5'd7; use_a = 0;
    expect_v("r7_nouse_stall", K_STALL, 32'h0);
    step();
    rna = 5'd7; use_a = 1; we = 1; wn = 5'd7; d = 32'd9;
    expect_v("r7_fwd_stall", K_STALL, 32'h0);
    expect_v("r7_fwd_qa", K_QA, 32'd9);
    step();
    rna = 5'd7; use_a = 1;
    expect_v("r7_clr_busy", K_BUSY, 32'h0);
    expect_v("r7_clr_stall", K_STALL, 32'h0);
    expect_v("r7_clr_qa", K_QA, 32'd9);

    // Port B hazard on r8, then flush clears it
    step();
    issue_en = 1; issue_rn = 5'd8;
    step();
    rna = 5'd8; rnb = 5'd8; use_b = 1;
    expect_v("r8_stall_b", K_STALL, 32'h1);
    step();
    flush = 1; rnb = 5'd8;
    step();
    rnb = 5'd8; use_b = 1;
    expect_v("flush_busy", K_BUSY, 32'h0);
    expect_v("flush_stall", K_STALL, 32'h0);

    // Issue + writeback + flush to r4 together; r9 busy beforehand
    step();
    issue_en = 1; issue_rn = 5'd9;
    step();
    issue_en = 1; issue_rn = 5'd4; we = 1; wn = 5'd4; d = 32'hA5A5_0004; flush = 1;
    rna = 5'd4;
    expect_v("combo_pre_busy", K_BUSY, 32'h0000_0200);
    expect_v("combo_byp_qa", K_QA, 32'hA5A5_0004);
    step();
    rna = 5'd4;
    expect_v("combo_qa", K_QA, 32'hA5A5_0004);
    expect_v("combo_busy", K_BUSY, 32'h0000_0010);

    // Writeback to a non-busy register, then retire r4
    step();
    we = 1; wn = 5'd10; d = 32'h0000_BEEF;
    step();
    rna = 5'd10;
    expect_v("nonbusy_qa", K_QA, 32'h0000_BEEF);
    expect_v("nonbusy_busy", K_BUSY, 32'h0000_0010);
    we = 1; wn = 5'd4; d = 32'h0000_0044;
    step();
    rna = 5'd4;
    expect_v("r4_retire_busy", K_BUSY, 32'h0);
    expect_v("r4_retire_qa", K_QA, 32'h0000_0044);

`ifdef REGFILE_SB_PARITY_EN
    // Corrupt stored data of r2 so its parity no longer matches
    step();
    we = 1; wn = 5'd2; d = 32'h0000_0001;
    step();
    rna = 5'd2;
    expect_v("par_clean", K_PERR_A, 32'h0);
    step();
    force dut.reg_q[2] = 32'h0000_0000;
    rna = 5'd2;
    expect_v("par_r2_err", K_PERR_A, 32'h1);
    step();
    rna = 5'd3;
    expect_v("par_r3_ok", K_PERR_A, 32'h0);
    step();
    release dut.reg_q[2];
`endif

    // Let the monitor drain the queue, bounded
    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
